alu_multicycle: RTL and testbench

//  Parametrised, registered ALU for the datapath; successor to the 8-bit combinational ALU.

---
 rtl/alu_multicycle.sv | 150 +++++++++++++++
 tb/tb_alu_multicycle.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Registered multi-cycle ALU: arithmetic/logic ops in one step, shifts one bit per cycle.
// Latency: 1 cycle for non-shift ops (and shift count 0), k+1 cycles for a k-bit shift.
// Backpressure: a response is held in DONE until rsp_ready; req_ready is low outside IDLE.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake; alu_cmd, inA, inB, sc_i sampled on accept
//   rsp_valid/rsp_ready        response handshake; rslt, sc_o, pari, zero, eq held while valid
module alu_multicycle #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [2:0]   alu_cmd,
  input  logic [W-1:0] inA,
  input  logic [W-1:0] inB,
  input  logic         sc_i,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rslt,
  output logic         sc_o,
  output logic         pari,
  output logic         zero,
  output logic         eq
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  acc;
  logic [CW-1:0] cnt;
  logic          dir_r;     // 1 = LSR, 0 = LSL
  logic          fill_r;

  logic          accept;
  logic          is_shift;
  logic          go_shift;
  logic [CW-1:0] k;
  logic [W-1:0]  op_rslt;
  logic          op_co;
  logic [W-1:0]  acc_step;
  logic          step_out;

  assign accept   = req_valid & (state == S_IDLE) & ~reset;
  assign is_shift = (alu_cmd[2:1] == 2'b00);
  assign go_shift = is_shift & (k != '0);

  // Shift amounts of W or more all behave as a full-width shift.
  always_comb begin
    k = inA[CW-1:0];
    if (inA >= W'(W))
      k = CW'(W);
  end

  // Single-step result for everything except a nonzero shift.
  always_comb begin
    op_rslt = '0;
    op_co   = 1'b0;
    case (alu_cmd)
      3'b000, 3'b001: op_rslt = inB;  // only reached with k == 0
      3'b010: op_rslt = inA;
      3'b011: {op_co, op_rslt} = {1'b0, inB} + (W+1)'(1);
      3'b100: {op_co, op_rslt} = {1'b0, inA} + {1'b0, inB} + {{W{1'b0}}, sc_i};
      3'b101: op_rslt = inA ^ inB;
      3'b110: op_rslt = {{(W-1){1'b0}}, ^inB};
      default: op_rslt = inA & inB;
    endcase
  end

  // One serial shift step; step_out is the bit leaving the accumulator.
  always_comb begin
    if (dir_r) begin
      acc_step = {fill_r, acc[W-1:1]};
      step_out = acc[0];
    end else begin
      acc_step = {acc[W-2:0], fill_r};
      step_out = acc[W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = ~reset;
        if (accept)
          state_nxt = go_shift ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        if (cnt == CW'(1))
          state_nxt = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rslt   <= '0;
      sc_o   <= 1'b0;
      pari   <= 1'b0;
      zero   <= 1'b0;
      eq     <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      dir_r  <= 1'b0;
      fill_r <= 1'b0;
    end else if (accept) begin
      eq     <= (inA == inB);
      acc    <= inB;
      cnt    <= k;
      dir_r  <= alu_cmd[0];
      fill_r <= sc_i;
      if (!go_shift) begin
        rslt <= op_rslt;
        sc_o <= op_co;
        pari <= ^op_rslt;
        zero <= (op_rslt == '0);
      end
    end else if (state == S_SHIFT) begin
      acc <= acc_step;
      cnt <= cnt - CW'(1);
      // Output registers are only written on the final step, so flags match rslt.
      if (cnt == CW'(1)) begin
        rslt <= acc_step;
        sc_o <= step_out;
        pari <= ^acc_step;
        zero <= (acc_step == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] alu_cmd;
  logic [7:0] inA;
  logic [7:0] inB;
  logic       sc_i;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rslt;
  logic       sc_o;
  logic       pari;
  logic       zero;
  logic       eq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] rslt;
    logic       sc_o;
    logic       pari;
    logic       zero;
    logic       eq;
    int         lat;
  } exp_t;

  exp_t sb[$];

  alu_multicycle #(.W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .alu_cmd  (alu_cmd),
    .inA      (inA),
    .inB      (inB),
    .sc_i     (sc_i),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rslt     (rslt),
    .sc_o     (sc_o),
    .pari     (pari),
    .zero     (zero),
    .eq       (eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: shifts use whole-word shift operators with a fill mask.
  function automatic exp_t model(input logic [2:0] cmd, input logic [7:0] a,
                                 input logic [7:0] b, input logic ci);
    exp_t        e;
    logic [15:0] t;
    logic [8:0]  s;
    int          k;
    e.rslt = 8'h00;
    e.sc_o = 1'b0;
    e.lat  = 1;
    e.eq   = (a == b);
    k = (a >= 8'd8) ? 8 : int'(a);
    case (cmd)
      3'd0: begin
        t = {8'h00, b} << k;
        e.rslt = t[7:0] | (ci ? 8'((16'h1 << k) - 16'h1) : 8'h00);
        e.sc_o = t[8];
        e.lat  = k + 1;
      end
      3'd1: begin
        t = {b, 8'h00} >> k;
        e.rslt = t[15:8] | (ci ? ~(8'hFF >> k) : 8'h00);
        e.sc_o = t[7];
        e.lat  = k + 1;
      end
      3'd2: e.rslt = a;
      3'd3: begin
        s = {1'b0, b} + 9'd1;
        e.rslt = s[7:0];
        e.sc_o = s[8];
      end
      3'd4: begin
        s = {1'b0, a} + {1'b0, b} + {8'h00, ci};
        e.rslt = s[7:0];
        e.sc_o = s[8];
      end
      3'd5: e.rslt = a ^ b;
      3'd6: e.rslt = {7'b0, ^b};
      default: e.rslt = a & b;
    endcase
    e.pari = ^e.rslt;
    e.zero = (e.rslt == 8'h00);
    return e;
  endfunction

  // Issue one op, wait for its response, check it, and optionally hold it for `hold` cycles.
  task automatic run_op(input string tag, input logic [2:0] cmd, input logic [7:0] a,
                        input logic [7:0] b, input logic ci, input int hold);
    int   guard;
    int   lat;
    exp_t e;
    guard = 0;
    rsp_ready = (hold == 0);
    while (!req_ready && guard < 50) begin
      step();
      guard++;
    end
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    alu_cmd   = cmd;
    inA       = a;
    inB       = b;
    sc_i      = ci;
    req_valid = 1'b1;
    sb.push_back(model(cmd, a, b, ci));
    step();
    req_valid = 1'b0;
    // Operands change after accept and must not affect the result.
    alu_cmd = 3'($urandom);
    inA     = 8'($urandom);
    inB     = 8'($urandom);
    sc_i    = 1'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      step();
      lat++;
    end
    e = sb.pop_front();
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, ".latency"}, 32'(lat), 32'(e.lat));
    check({tag, ".rslt"}, 32'(rslt), 32'(e.rslt));
    check({tag, ".sc_o"}, 32'(sc_o), 32'(e.sc_o));
    check({tag, ".pari"}, 32'(pari), 32'(e.pari));
    check({tag, ".zero"}, 32'(zero), 32'(e.zero));
    check({tag, ".eq"}, 32'(eq), 32'(e.eq));
    check({tag, ".busy"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rslt"}, 32'(rslt), 32'(e.rslt));
      check({tag, ".hold_flags"}, 32'({sc_o, pari, zero, eq}),
            32'({e.sc_o, e.pari, e.zero, e.eq}));
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    check({tag, ".released"}, 32'(rsp_valid), 32'd0);
    check({tag, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    alu_cmd   = 3'd0;
    inA       = 8'h00;
    inB       = 8'h00;
    sc_i      = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    #1;
    check("rst.outputs", 32'({rslt, sc_o, pari, zero, eq}), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd1);

    run_op("add",      3'd4, 8'hF0, 8'h20, 1'b1, 0);
    run_op("lsl1",     3'd0, 8'h01, 8'h81, 1'b0, 0);
    run_op("lsl3",     3'd0, 8'h03, 8'h81, 1'b1, 0);
    run_op("lsr_clamp",3'd1, 8'h09, 8'h80, 1'b0, 0);
    run_op("lsr0",     3'd1, 8'h00, 8'hA5, 1'b1, 0);
    run_op("lsl8",     3'd0, 8'h08, 8'h5A, 1'b1, 0);
    run_op("par",      3'd6, 8'h00, 8'h07, 1'b0, 0);
    run_op("inc",      3'd3, 8'h00, 8'hFF, 1'b0, 0);
    run_op("xor_eq",   3'd5, 8'h5A, 8'h5A, 1'b0, 0);
    run_op("mov",      3'd2, 8'h3C, 8'h00, 1'b1, 0);
    run_op("and",      3'd7, 8'hF3, 8'h3E, 1'b1, 0);
    run_op("bp",       3'd4, 8'h7F, 8'h01, 1'b0, 5);

    // Reset during the third step of a 6-bit shift abandons the op.
    check("mid.req_ready", 32'(req_ready), 32'd1);
    alu_cmd   = 3'd0;
    inA       = 8'h06;
    inB       = 8'h06;
    sc_i      = 1'b1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mid.outputs", 32'({rslt, sc_o, pari, zero, eq}), 32'd0);
    check("mid.rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid.req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("mid.no_rsp", 32'(rsp_valid), 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      logic [2:0] c;
      logic [7:0] a;
      c = 3'($urandom);
      a = (c < 3'd2) ? 8'($urandom_range(0, 11)) : 8'($urandom);
      run_op("rand", c, a, 8'($urandom), 1'($urandom), i % 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
